// File: rtl/verlet_pkg.sv
// Shared definitions for the Verlet phase sequencer: phase encoding,
// constraint-region base default and per-core slice helpers.
package verlet_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VERLET = 3'd1,
      S_VDRAIN = 3'd2,
      S_FIX    = 3'd3,
      S_FDRAIN = 3'd4,
      S_DONE   = 3'd5
   } phase_t;

   localparam logic [7:0] CNST_BASE_DEF = 8'h80;

   // First point owned by a core.
   function automatic int unsigned slice_base(input int unsigned core, input int unsigned ppc);
      return core * ppc;
   endfunction

   // Points owned by a core; the last core also takes the remainder.
   function automatic int unsigned slice_cnt(input int unsigned base, input logic last,
                                             input int unsigned n_points, input int unsigned ppc);
      return last ? (n_points - base) : ppc;
   endfunction

   // Constraints per pass; the final point of the rope has no right neighbour.
   function automatic int unsigned slice_ncs(input int unsigned cnt, input logic last);
      return last ? (cnt - 1) : cnt;
   endfunction

endpackage

// File: rtl/verlet_phase_sequencer_if.sv
// Scheduler / RAM-side signal bundle of the Verlet phase sequencer.
// CYCLE_PROFILE_EN adds the verlet_cycles / fix_cycles profile outputs.
interface verlet_phase_sequencer_if #(
   parameter int unsigned CORE_ID_W = 2,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned STEP_W    = 8
);
   logic                 start;
   logic [CORE_ID_W-1:0] core_id;
   logic                 is_last_core;
   logic [STEP_W-1:0]    n_steps;
   logic                 stall;
   logic                 verlet_en;
   logic                 fix_cnst_en;
   logic                 ram_rd_valid;
   logic [ADDR_W-1:0]    ram_rd_addr;
   logic                 ram_wr_en;
   logic [ADDR_W-1:0]    ram_wr_addr;
   logic [STEP_W-1:0]    step_cnt;
   logic                 busy;
   logic                 done;
`ifdef CYCLE_PROFILE_EN
   logic [31:0]          verlet_cycles;
   logic [31:0]          fix_cycles;

   modport master (
      output start, core_id, is_last_core, n_steps, stall,
      input  verlet_en, fix_cnst_en, ram_rd_valid, ram_rd_addr, ram_wr_en, ram_wr_addr,
             step_cnt, busy, done, verlet_cycles, fix_cycles
   );
   modport slave (
      input  start, core_id, is_last_core, n_steps, stall,
      output verlet_en, fix_cnst_en, ram_rd_valid, ram_rd_addr, ram_wr_en, ram_wr_addr,
             step_cnt, busy, done, verlet_cycles, fix_cycles
   );
`else
   modport master (
      output start, core_id, is_last_core, n_steps, stall,
      input  verlet_en, fix_cnst_en, ram_rd_valid, ram_rd_addr, ram_wr_en, ram_wr_addr,
             step_cnt, busy, done
   );
   modport slave (
      input  start, core_id, is_last_core, n_steps, stall,
      output verlet_en, fix_cnst_en, ram_rd_valid, ram_rd_addr, ram_wr_en, ram_wr_addr,
             step_cnt, busy, done
   );
`endif
endinterface

// File: rtl/sim_pipe_delay.sv
// Fixed-latency shift register standing in for the core datapath pipeline.
module sim_pipe_delay #(
   parameter int unsigned DATA_W = 9,
   parameter int unsigned LAT    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [LAT-1:0][DATA_W-1:0] sr;

   // Shift one stage per cycle; never frozen by RAM stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < int'(LAT); i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[LAT-1];

endmodule

// File: rtl/verlet_phase_sequencer.sv
// Per-core sequencer for the Verlet cloth/rope solver: streams integrate-phase
// and constraint-fix read addresses over this core's slice, n_steps times, and
// issues write-backs through a fixed-latency datapath model.
// CYCLE_PROFILE_EN adds saturating per-phase cycle counters.
module verlet_phase_sequencer
   import verlet_pkg::*;
#(
   parameter int unsigned       N_POINTS   = 16,
   parameter int unsigned       N_CORES    = 4,
   parameter int unsigned       CORE_ID_W  = 2,
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       PIPE_LAT   = 3,
   parameter int unsigned       CNST_ITERS = 2,
   parameter int unsigned       STEP_W     = 8,
   parameter logic [ADDR_W-1:0] CNST_BASE  = ADDR_W'(CNST_BASE_DEF)
) (
   input logic                     clk,
   input logic                     reset,
   verlet_phase_sequencer_if.slave bus
);

   localparam int unsigned PPC    = N_POINTS / N_CORES;
   localparam int unsigned CNT_W  = $clog2(N_POINTS + 1);
   localparam int unsigned PASS_W = (CNST_ITERS > 1) ? $clog2(CNST_ITERS) : 1;
   localparam int unsigned DRN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(PIPE_LAT - 1);
   localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(CNST_ITERS - 1);

   phase_t             state;
   logic [ADDR_W-1:0]  base_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   ncs_r;
   logic [CNT_W-1:0]   issued;
   logic [PASS_W-1:0]  pass_cnt;
   logic [DRN_W-1:0]   drain_cnt;
   logic [STEP_W-1:0]  n_steps_r;
   logic [STEP_W-1:0]  step_cnt_r;
   logic               verlet_en_r;
   logic               fix_en_r;
   logic               rd_valid_r;
   logic [ADDR_W-1:0]  rd_addr_r;
   logic               busy_r;
   logic               done_r;
   logic [ADDR_W:0]    wb_q;

   int unsigned        base_i;
   int unsigned        cnt_i;
   int unsigned        ncs_i;
   logic [ADDR_W-1:0]  base_c;
   logic [CNT_W-1:0]   cnt_c;
   logic [CNT_W-1:0]   ncs_c;
   logic [ADDR_W-1:0]  cnst_base_c;
   logic [ADDR_W-1:0]  v_addr_c;
   logic [ADDR_W-1:0]  f_addr_c;
   logic               go_c;
   logic               fix_go_c;
   logic               pass_end_c;
   logic               last_step_c;

   // Slice of the point array owned by this core, from the start-time inputs.
   always_comb begin
      base_i = slice_base(32'(bus.core_id), PPC);
      cnt_i  = slice_cnt(base_i, bus.is_last_core, N_POINTS, PPC);
      ncs_i  = slice_ncs(cnt_i, bus.is_last_core);
      base_c = ADDR_W'(base_i);
      cnt_c  = CNT_W'(cnt_i);
      ncs_c  = CNT_W'(ncs_i);
   end

   // Next issue addresses and phase-boundary conditions.
   always_comb begin
      cnst_base_c = CNST_BASE + base_r;
      v_addr_c    = base_r + ADDR_W'(issued);
      f_addr_c    = cnst_base_c + ADDR_W'(issued);
      go_c        = !bus.stall;
      fix_go_c    = !bus.stall && (ncs_r != '0);
      pass_end_c  = ((state == S_FDRAIN) && (drain_cnt == DRAIN_LAST)) ||
                    ((state == S_FIX) && (ncs_r == '0));
      last_step_c = (step_cnt_r + STEP_W'(1)) == n_steps_r;
   end

   // Phase FSM with registered outputs; each phase entry issues its first address on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         base_r      <= '0;
         cnt_r       <= '0;
         ncs_r       <= '0;
         issued      <= '0;
         pass_cnt    <= '0;
         drain_cnt   <= '0;
         n_steps_r   <= '0;
         step_cnt_r  <= '0;
         verlet_en_r <= 1'b0;
         fix_en_r    <= 1'b0;
         rd_valid_r  <= 1'b0;
         rd_addr_r   <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (pass_end_c) begin
            if (pass_cnt == PASS_LAST) begin
               pass_cnt   <= '0;
               step_cnt_r <= step_cnt_r + STEP_W'(1);
               fix_en_r   <= 1'b0;
               if (last_step_c) begin
                  state <= S_DONE;
               end else begin
                  state       <= S_VERLET;
                  verlet_en_r <= 1'b1;
                  rd_valid_r  <= go_c;
                  rd_addr_r   <= base_r;
                  issued      <= CNT_W'(go_c);
               end
            end else begin
               pass_cnt   <= pass_cnt + PASS_W'(1);
               state      <= S_FIX;
               rd_valid_r <= fix_go_c;
               rd_addr_r  <= cnst_base_c;
               issued     <= CNT_W'(fix_go_c);
            end
         end else begin
            case (state)
               S_IDLE: begin
                  busy_r <= bus.start;
                  if (bus.start) begin
                     base_r     <= base_c;
                     cnt_r      <= cnt_c;
                     ncs_r      <= ncs_c;
                     n_steps_r  <= bus.n_steps;
                     step_cnt_r <= '0;
                     pass_cnt   <= '0;
                     if (bus.n_steps == '0) begin
                        state <= S_DONE;
                     end else begin
                        state       <= S_VERLET;
                        verlet_en_r <= 1'b1;
                        rd_valid_r  <= go_c;
                        rd_addr_r   <= base_c;
                        issued      <= CNT_W'(go_c);
                     end
                  end
               end
               S_VERLET: begin
                  if (issued == cnt_r) begin
                     state      <= S_VDRAIN;
                     rd_valid_r <= 1'b0;
                     drain_cnt  <= '0;
                  end else if (bus.stall) begin
                     rd_valid_r <= 1'b0;
                  end else begin
                     rd_valid_r <= 1'b1;
                     rd_addr_r  <= v_addr_c;
                     issued     <= issued + CNT_W'(1);
                  end
               end
               S_VDRAIN: begin
                  if (drain_cnt == DRAIN_LAST) begin
                     state       <= S_FIX;
                     verlet_en_r <= 1'b0;
                     fix_en_r    <= 1'b1;
                     pass_cnt    <= '0;
                     rd_valid_r  <= fix_go_c;
                     rd_addr_r   <= cnst_base_c;
                     issued      <= CNT_W'(fix_go_c);
                  end else begin
                     drain_cnt <= drain_cnt + DRN_W'(1);
                  end
               end
               S_FIX: begin
                  if (issued == ncs_r) begin
                     state      <= S_FDRAIN;
                     rd_valid_r <= 1'b0;
                     drain_cnt  <= '0;
                  end else if (bus.stall) begin
                     rd_valid_r <= 1'b0;
                  end else begin
                     rd_valid_r <= 1'b1;
                     rd_addr_r  <= f_addr_c;
                     issued     <= issued + CNT_W'(1);
                  end
               end
               S_FDRAIN: begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
               S_DONE: begin
                  done_r <= 1'b1;
                  busy_r <= 1'b1;
                  state  <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Write-back path: read strobe and address delayed by the datapath latency.
   sim_pipe_delay #(
      .DATA_W (ADDR_W + 1),
      .LAT    (PIPE_LAT)
   ) u_wb_delay (
      .clk   (clk),
      .rst_n (reset),
      .din   ({rd_valid_r, rd_addr_r}),
      .dout  (wb_q)
   );

   assign bus.verlet_en    = verlet_en_r;
   assign bus.fix_cnst_en  = fix_en_r;
   assign bus.ram_rd_valid = rd_valid_r;
   assign bus.ram_rd_addr  = rd_addr_r;
   assign bus.ram_wr_en    = wb_q[ADDR_W];
   assign bus.ram_wr_addr  = wb_q[ADDR_W-1:0];
   assign bus.step_cnt     = step_cnt_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;

`ifdef CYCLE_PROFILE_EN
   logic [31:0] verlet_cyc_r;
   logic [31:0] fix_cyc_r;

   // Saturating per-phase cycle counters, cleared by an accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         verlet_cyc_r <= '0;
         fix_cyc_r    <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         verlet_cyc_r <= '0;
         fix_cyc_r    <= '0;
      end else begin
         if (verlet_en_r && (verlet_cyc_r != '1)) verlet_cyc_r <= verlet_cyc_r + 32'd1;
         if (fix_en_r && (fix_cyc_r != '1))       fix_cyc_r    <= fix_cyc_r + 32'd1;
      end
   end

   assign bus.verlet_cycles = verlet_cyc_r;
   assign bus.fix_cycles    = fix_cyc_r;
`endif

endmodule
